serdes_tx_sched: RTL and testbench
==================================

Name: serdes_tx_sched

Overview:
- Transmit-side scheduler for the serial SERDES lane.
- Two byte producers share one serial output. The block round-robin arbitrates between them, frames the winning byte, and shifts it out LSB first on a single wire whose idle level is 0.
- It sits between the on-chip byte sources and the serial pin that feeds the receiver.

Parameters:
- GAP_BITS, 1, mandatory idle-0 bit times after each frame. Legal range is 0..15.
- PARITY_ODD, 0, parity sense. 0 means even parity over data+id; 1 means odd.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- ena  in  1  global enable. It gates new acceptances only.
- req0_valid  in  1  requester 0 has a byte.
- req0_data  in  8  requester 0 byte.
- req0_ready  out  1  requester 0 byte accepted this cycle.
- req1_valid  in  1  requester 1 has a byte.
- req1_data  in  8  requester 1 byte.
- req1_ready  out  1  requester 1 byte accepted this cycle.
- ser_out  out  1  registered serial line.
- busy  out  1  high whenever state is not IDLE.
- grant_id  out  1  id of the frame in flight; holds its last value when idle.
- frame_done  out  1  one-cycle pulse.

Behaviour:
- Reset (async, rst_n=0) forces all outputs to 0: ser_out, busy, grant_id, frame_done, and both ready signals.
  - State goes to IDLE and last_grant goes to 1, so req0 wins the first tie.
  - Reset asserted mid-frame aborts the frame immediately; ser_out=0 with no completion pulse.
- Frame format, 11 bits in order:
  - start bit = 1;
  - data[0]..data[7];
  - id bit (0 or 1);
  - parity bit.
  - Parity = ^{data,id} ^ PARITY_ODD.
- States: IDLE -> START -> DATA -> ID -> PARITY -> GAP -> IDLE.
  - GAP is skipped when GAP_BITS=0.
  - A 3-bit bit counter runs in DATA; a 4-bit counter runs in GAP.
- IDLE:
  - ser_out=0.
  - If ena=1 and at least one valid is high, grant combinationally:
    - if only one requester is valid, it wins;
    - if both are valid, the requester that is not last_grant wins.
  - The winner's ready is high in this same cycle; the handshake is valid&&ready.
  - On that edge the block latches data and id, updates last_grant, and moves to START.
  - ready is never high outside IDLE, never high when ena=0, and never high for both requesters at once.
- Latency: a handshake in cycle N puts the start bit on ser_out in cycle N+1. Data bits follow in cycles N+2..N+9, id in N+10 and parity in N+11.
- frame_done is high in exactly the cycle the parity bit is on ser_out.
- GAP holds ser_out=0 for GAP_BITS cycles, then the block enters IDLE.
- The earliest next handshake is cycle N+12+GAP_BITS, giving a back-to-back period of 12+GAP_BITS cycles.
- ena falling mid-frame does not truncate the frame: it completes, then the block holds in IDLE.
- Data, id and valid changes after acceptance have no effect on the frame in flight.

Decomposition:
- Shared package serdes_pkg holds:
  - state encoding enum (IDLE, START, DATA, ID, PARITY, GAP);
  - FRAME_BITS=11 and START_BIT=1'b1 constants;
  - a parity function.
- One natural sub-module: rr_arb2, the two-way round-robin grant with last_grant register. It has inputs req[1:0], enable and advance, and output gnt[1:0].

Test Plan:
- Single request: req0 0xA5 once after reset with ena=1.
  - Required: ready pulse in cycle N.
  - ser_out from N+1 = 1, 1,0,1,0,0,1,0,1, 0, 0, then 0 for GAP.
  - frame_done high at N+11 only.
- Simultaneous requests: req0=0x01 and req1=0x03 both valid from reset.
  - req0 is accepted first; its frame ends id=0, parity=1.
  - req1 is accepted at N+13; its frame ends id=1, parity=1.
  - grant_id is 0 then 1.
- Fairness: both requesters held valid for 4 frames.
  - Grants alternate 0,1,0,1.
  - No frame overlaps; every ready is a single cycle.
- ena gating: valid held with ena=0 for 50 cycles, then ena dropped mid-frame.
  - No ready while ena=0 and ser_out stays 0.
  - The frame in flight completes all 11 bits, then nothing further is sent.
- Reset mid-frame: rst_n=0 during data bit 4.
  - ser_out, busy and frame_done go to 0 asynchronously.
  - After release, req0 wins the first tie.
- Parameter sweep: GAP_BITS=0 and PARITY_ODD=1 with back-to-back 0x00 frames.
  - Period is 12 cycles.
  - Parity bit = 1 for id=0.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared types and helpers for the SERDES transmit scheduler.
package serdes_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_ID,
        S_PARITY,
        S_GAP
    } state_e;

    localparam int   FRAME_BITS = 11;
    localparam logic START_BIT  = 1'b1;

    function automatic logic frame_parity(input logic [7:0] data, input logic id, input logic odd);
        return ^{data, id} ^ odd;
    endfunction

endpackage

// File: rtl/serdes_tx_sched_rr_arb2.sv
// Two-way round-robin grant; on a tie the requester that did not win last time is chosen.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       enable,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (advance && (gnt != 2'b00)) begin
            last_grant_d = gnt[1];
        end
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/serdes_tx_sched.sv
// Arbitrates two byte producers and shifts framed bytes LSB first onto an idle-low serial line.
//   state    | meaning
//   S_IDLE   | line low, grant and accept a byte
//   S_START  | start bit on the line
//   S_DATA   | data bits 0..7
//   S_ID     | requester id bit
//   S_PARITY | parity bit, frame_done high
//   S_GAP    | mandatory idle-low bit times
module serdes_tx_sched #(
    parameter int GAP_BITS   = 1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       ser_out,
    output logic       busy,
    output logic       grant_id,
    output logic       frame_done
);

    import serdes_pkg::*;

    localparam int         DATA_BITS = FRAME_BITS - 3;
    localparam logic [3:0] GAP_LOAD  = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

    state_e               state_q, state_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [3:0]           gap_cnt_q, gap_cnt_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 id_q, id_d;
    logic                 ser_out_q, ser_out_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;

    logic       idle;
    logic       arb_en;
    logic       accept;
    logic [1:0] gnt;

    assign idle = (state_q == S_IDLE);

    // rst_n in the enable keeps both readies low while reset is held.
    assign arb_en = ena && idle && rst_n;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({req1_valid, req0_valid}),
        .enable  (arb_en),
        .advance (idle),
        .gnt     (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign accept     = |gnt;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        data_d    = data_q;
        id_d      = id_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    data_d  = gnt[1] ? req1_data : req0_data;
                    id_d    = gnt[1];
                    state_d = S_START;
                end
            end
            S_START: begin
                bit_cnt_d = 3'd0;
                state_d   = S_DATA;
            end
            S_DATA: begin
                if (bit_cnt_q == 3'd7) begin
                    state_d = S_ID;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            S_ID: begin
                state_d = S_PARITY;
            end
            S_PARITY: begin
                if (GAP_BITS == 0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = GAP_LOAD;
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Line value is decoded from the next state so ser_out is a clean flop output.
        ser_out_d = 1'b0;
        case (state_d)
            S_START:  ser_out_d = START_BIT;
            S_DATA:   ser_out_d = data_d[bit_cnt_d];
            S_ID:     ser_out_d = id_d;
            S_PARITY: ser_out_d = frame_parity(data_d, id_d, PARITY_ODD);
            default:  ser_out_d = 1'b0;
        endcase

        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_PARITY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= 3'd0;
            gap_cnt_q    <= 4'd0;
            data_q       <= '0;
            id_q         <= 1'b0;
            ser_out_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            data_q       <= data_d;
            id_q         <= id_d;
            ser_out_q    <= ser_out_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ser_out    = ser_out_q;
    assign busy       = busy_q;
    assign grant_id   = id_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_serdes_tx_sched.sv
// Self-checking bench: vector table, directed corner sequences and a frame-level timeline model.
module tb_serdes_tx_sched;

    localparam int G0   = 1;
    localparam int MAXC = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic       ena, v0, v1;
    logic [7:0] d0, d1;
    logic       r0, r1, ser, busy, gid, done;

    logic       ena_b, v0_b, v1_b;
    logic [7:0] d0_b, d1_b;
    logic       r0_b, r1_b, ser_b, busy_b, gid_b, done_b;

    always #5 clk = ~clk;

    serdes_tx_sched #(.GAP_BITS(G0), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
        .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
        .ser_out(ser), .busy(busy), .grant_id(gid), .frame_done(done)
    );

    serdes_tx_sched #(.GAP_BITS(0), .PARITY_ODD(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena_b),
        .req0_valid(v0_b), .req0_data(d0_b), .req0_ready(r0_b),
        .req1_valid(v1_b), .req1_data(d1_b), .req1_ready(r1_b),
        .ser_out(ser_b), .busy(busy_b), .grant_id(gid_b), .frame_done(done_b)
    );

    int nerr = 0;
    int nchk = 0;
    int cyc  = 0;
    bit model_en = 1'b0;

    // Timeline model: expected line/busy/done per absolute cycle, filled when a frame is accepted.
    bit m_line [MAXC];
    bit m_busy [MAXC];
    bit m_done [MAXC];
    int m_free;
    bit m_last;
    bit m_gid;

    typedef struct {
        logic       ena;
        logic       v0;
        logic [7:0] d0;
        logic       r0;
        logic       ser;
        logic       busy;
        logic       gid;
        logic       done;
    } vec_t;

    vec_t tbl [14];

    task automatic chk1(input string name, input logic act, input logic exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual=%b required=%b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = cyc; i < MAXC; i++) begin
            m_line[i] = 1'b0;
            m_busy[i] = 1'b0;
            m_done[i] = 1'b0;
        end
        m_free = cyc;
        m_last = 1'b1;
        m_gid  = 1'b0;
    endtask

    task automatic model_step();
        bit        idle_m, w0, w1, id;
        bit [7:0]  d;
        bit [10:0] fr;
        idle_m = (cyc >= m_free);
        w0 = 1'b0;
        w1 = 1'b0;
        if (idle_m && ena) begin
            if (v0 && v1) begin
                w0 = m_last;
                w1 = !m_last;
            end else begin
                w0 = v0;
                w1 = v1;
            end
        end
        chk1("model ready0", r0, w0);
        chk1("model ready1", r1, w1);
        chk1("model ser_out", ser, m_line[cyc]);
        chk1("model busy", busy, m_busy[cyc]);
        chk1("model frame_done", done, m_done[cyc]);
        chk1("model grant_id", gid, m_gid);
        if (w0 || w1) begin
            id = w1;
            d  = w1 ? d1 : d0;
            fr = {^{d, id}, id, d, 1'b1};
            for (int k = 0; k < 11; k++) m_line[cyc + 1 + k] = fr[k];
            for (int k = 1; k <= 11 + G0; k++) m_busy[cyc + k] = 1'b1;
            m_done[cyc + 11] = 1'b1;
            m_free = cyc + 12 + G0;
            m_last = id;
            m_gid  = id;
        end
    endtask

    task automatic tick_neg();
        @(negedge clk);
        if (model_en) model_step();
    endtask

    task automatic tick_pos();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick_neg();
            tick_pos();
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        model_en = 1'b0;
        #1;
        chk1("reset ser_out", ser, 1'b0);
        chk1("reset busy", busy, 1'b0);
        chk1("reset frame_done", done, 1'b0);
        chk1("reset grant_id", gid, 1'b0);
        chk1("reset ready0", r0, 1'b0);
        chk1("reset ready1", r1, 1'b0);
        chk1("reset b ser_out", ser_b, 1'b0);
        chk1("reset b busy", busy_b, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        cyc += 2;
        rst_n = 1'b1;
        model_reset();
        model_en = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $display("Result: errors=%0d of %0d checks", nerr + 1, nchk + 1);
        $fatal(1);
    end

    initial begin
        int        n, hs_cnt, done_cnt, rdy_cnt;
        int        g_id [$];
        int        g_cyc [$];
        int        hb [$];
        logic      sb [64];
        logic      db [64];

        ena = 1'b0; v0 = 1'b0; v1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
        ena_b = 1'b0; v0_b = 1'b0; v1_b = 1'b0; d0_b = 8'h00; d1_b = 8'h00;

        // Single 0xA5 frame: start, LSB-first data, id=0, parity=0, one gap bit.
        tbl[0]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        #3;
        do_reset();

        for (int i = 0; i < 14; i++) begin
            ena = tbl[i].ena;
            v0  = tbl[i].v0;
            d0  = tbl[i].d0;
            tick_neg();
            chk1("table ready0", r0, tbl[i].r0);
            chk1("table ser_out", ser, tbl[i].ser);
            chk1("table busy", busy, tbl[i].busy);
            chk1("table grant_id", gid, tbl[i].gid);
            chk1("table frame_done", done, tbl[i].done);
            tick_pos();
        end

        // Both valid from reset.
        v0 = 1'b1; d0 = 8'h01; v1 = 1'b1; d1 = 8'h03;
        do_reset();
        for (int k = 0; k < 27; k++) begin
            tick_neg();
            case (k)
                0:  begin chk1("tie ready0 first", r0, 1'b1); chk1("tie ready1 first", r1, 1'b0); end
                1:  chk1("tie grant_id 0", gid, 1'b0);
                10: chk1("tie id bit 0", ser, 1'b0);
                11: begin chk1("tie parity req0", ser, 1'b1); chk1("tie done req0", done, 1'b1); end
                13: begin chk1("tie ready1 N+13", r1, 1'b1); chk1("tie ready0 N+13", r0, 1'b0); end
                14: chk1("tie grant_id 1", gid, 1'b1);
                23: chk1("tie id bit 1", ser, 1'b1);
                24: begin chk1("tie parity req1", ser, 1'b1); chk1("tie done req1", done, 1'b1); end
                default: ;
            endcase
            tick_pos();
            if (k == 13) begin
                v0 = 1'b0;
                v1 = 1'b0;
            end
        end

        // Fairness with both held valid and data churning after acceptance.
        v0 = 1'b1; v1 = 1'b1;
        for (int k = 0; k < 80 && g_id.size() < 4; k++) begin
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            tick_neg();
            if (r0 || r1) begin
                g_id.push_back(r1 ? 1 : 0);
                g_cyc.push_back(cyc);
                chk1("fair single ready", r0 && r1, 1'b0);
            end
            tick_pos();
        end
        v0 = 1'b0; v1 = 1'b0;
        chki("fair grant count", g_id.size(), 4);
        for (int i = 0; i < g_id.size(); i++) begin
            chki("fair grant order", g_id[i], i % 2);
            if (i > 0) chki("fair period", g_cyc[i] - g_cyc[i-1], 12 + G0);
        end
        run(14);

        // ena gating, then ena dropped mid-frame.
        ena = 1'b0; v0 = 1'b1; d0 = 8'h5C;
        for (int k = 0; k < 50; k++) begin
            tick_neg();
            chk1("gate no ready", r0, 1'b0);
            chk1("gate line idle", ser, 1'b0);
            tick_pos();
        end
        ena = 1'b1;
        tick_neg();
        chk1("gate accept", r0, 1'b1);
        tick_pos();
        run(2);
        ena = 1'b0;
        done_cnt = 0;
        rdy_cnt  = 0;
        for (int k = 0; k < 40; k++) begin
            tick_neg();
            if (done) done_cnt++;
            if (r0 || r1) rdy_cnt++;
            tick_pos();
        end
        chki("gate frame completes", done_cnt, 1);
        chki("gate no further accept", rdy_cnt, 0);
        v0 = 1'b0;

        // Reset during data bit 4 of an 0xFF frame.
        ena = 1'b1; v0 = 1'b1; d0 = 8'hFF;
        tick_neg();
        chk1("rst accept", r0, 1'b1);
        tick_pos();
        v0 = 1'b0;
        run(5);
        chk1("rst data bit4 high", ser, 1'b1);
        v0 = 1'b1; d0 = 8'h55; v1 = 1'b1; d1 = 8'hAA;
        #2;
        do_reset();
        tick_neg();
        chk1("rst tie ready0", r0, 1'b1);
        chk1("rst tie ready1", r1, 1'b0);
        tick_pos();
        v0 = 1'b0; v1 = 1'b0;
        run(14);

        // Randomized traffic against the timeline model.
        for (int k = 0; k < 1200; k++) begin
            ena = ($urandom_range(7) != 0);
            v0  = ($urandom_range(2) != 0);
            v1  = ($urandom_range(2) != 0);
            d0  = 8'($urandom);
            d1  = 8'($urandom);
            tick_neg();
            tick_pos();
        end
        ena = 1'b0; v0 = 1'b0; v1 = 1'b0;
        run(14);

        // GAP_BITS=0, odd parity, back-to-back 0x00 frames.
        ena_b = 1'b1; v0_b = 1'b1; d0_b = 8'h00;
        for (int k = 0; k < 40; k++) begin
            tick_neg();
            if (r0_b) hb.push_back(k);
            sb[k] = ser_b;
            db[k] = done_b;
            tick_pos();
        end
        v0_b = 1'b0;
        hs_cnt = hb.size();
        chki("sweep frame count", hs_cnt, 4);
        for (int i = 1; i < hb.size(); i++) chki("sweep period", hb[i] - hb[i-1], 12);
        if (hb.size() > 0 && hb[0] + 12 < 40) begin
            n = hb[0];
            chk1("sweep start bit", sb[n + 1], 1'b1);
            chk1("sweep data bit", sb[n + 2], 1'b0);
            chk1("sweep id bit", sb[n + 10], 1'b0);
            chk1("sweep odd parity", sb[n + 11], 1'b1);
            chk1("sweep done", db[n + 11], 1'b1);
            chk1("sweep done early", db[n + 10], 1'b0);
        end else begin
            chki("sweep first handshake", hb.size(), 4);
        end
        run(14);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
